// File: rtl/fetch.sv
// Instruction fetch stage.
// Owns the program counter and keeps at most one request outstanding to a
// variable-latency instruction memory. The fetched pc/instr pair is held in
// registers for decode, which can stall it or redirect fetch to a new target.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        fin,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);

  // IDLE: nothing outstanding, WAIT: request out, HOLD: captured word held under stall
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] next_pc;
  logic [31:0] req_addr;
  logic [31:0] target;
  logic        kill;
  logic        issue;
  logic        capture;

  // Redirect targets are word aligned; the low two bits are simply cleared
  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr = req_addr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a redirect always falls back to IDLE except while a
  // request is still in flight, which must be allowed to finish
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!redirect && enable && !stall) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          state_nxt = (capture && stall) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs: request strobe, issue decision and response capture
  always_comb begin
    imem_req = 1'b0;
    issue    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: issue = !redirect && enable && !stall;
      WAIT: begin
        imem_req = 1'b1;
        capture  = imem_valid && !kill && !redirect;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // Fetch address bookkeeping: latch the request address on issue, advance
  // on a captured response, jump on redirect (latest redirect wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc  <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (issue) begin
        req_addr <= next_pc;
      end
      if (redirect) begin
        next_pc <= target;
      end else if (capture) begin
        next_pc <= req_addr + 32'd4;
      end
    end
  end

  // Kill marks an in-flight request whose response must be thrown away
  // because a redirect arrived while it was still outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      kill <= 1'b0;
    end else if (state == WAIT) begin
      if (imem_valid) begin
        kill <= 1'b0;
      end else if (redirect) begin
        kill <= 1'b1;
      end
    end else begin
      kill <= 1'b0;
    end
  end

  // Decode-facing registers: load on capture, drop to a bubble once decode
  // consumes the word or a redirect squashes it, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      valid <= 1'b0;
      fin   <= 1'b0;
    end else begin
      fin <= capture;
      if (capture) begin
        pc    <= req_addr;
        instr <= imem_rdata;
        valid <= 1'b1;
      end else if (redirect || (valid && !stall)) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule
